// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers. Callers zero-extend to code_t and
// truncate the result back to their own width, so any WIDTH up to MAX_WIDTH works.
package gray_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   typedef logic [MAX_WIDTH-1:0] code_t;

   function automatic code_t bin2gray(input code_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero bits above the caller's width stay zero.
   function automatic code_t gray2bin(input code_t gray);
      code_t bin;
      bin = '0;
      bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
      for (int i = int'(MAX_WIDTH) - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// Control and result bundle for the Gray code counter.
interface gray_code_counter_if #(
   parameter int unsigned WIDTH = 4
) ();

   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_gray;
   logic [WIDTH-1:0] gray_out;
   logic [WIDTH-1:0] bin_out;
   logic             wrap;
   logic             at_limit;

   modport master (
      output en, up_dn, load, load_gray,
      input  gray_out, bin_out, wrap, at_limit
   );

   modport slave (
      input  en, up_dn, load, load_gray,
      output gray_out, bin_out, wrap, at_limit
   );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder used on the load path.
module gray_to_bin
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin_c
);

   assign bin_c = WIDTH'(gray2bin(code_t'(gray)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray and binary outputs, Gray load,
// wrap or saturate mode, wrap pulse and limit flag.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned RESET_VAL = 0,
   parameter int unsigned SATURATE  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   gray_code_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] ZERO_VAL = '0;
   localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic             wrap_q;
   logic             at_limit_q;

   logic [WIDTH-1:0] load_bin_c;
   logic [WIDTH-1:0] next_bin_c;
   logic [WIDTH-1:0] next_gray_c;
   logic             next_wrap_c;
   logic             next_at_limit_c;

   gray_to_bin #(.WIDTH(WIDTH)) u_load_dec (
      .gray  (bus.load_gray),
      .bin_c (load_bin_c)
   );

   // Next count: load beats enable; an edge step either wraps (pulse) or saturates.
   always_comb begin
      next_bin_c  = bin_q;
      next_wrap_c = 1'b0;
      if (bus.load) begin
         next_bin_c = load_bin_c;
      end else if (bus.en) begin
         if (bus.up_dn) begin
            if (bin_q != MAX_VAL) begin
               next_bin_c = bin_q + WIDTH'(1);
            end else if (SATURATE == 0) begin
               next_bin_c  = ZERO_VAL;
               next_wrap_c = 1'b1;
            end
         end else begin
            if (bin_q != ZERO_VAL) begin
               next_bin_c = bin_q - WIDTH'(1);
            end else if (SATURATE == 0) begin
               next_bin_c  = MAX_VAL;
               next_wrap_c = 1'b1;
            end
         end
      end
      // Gray derived from the next count so both outputs update on the same edge.
      next_gray_c     = WIDTH'(bin2gray(code_t'(next_bin_c)));
      next_at_limit_c = bus.up_dn ? (next_bin_c == MAX_VAL) : (next_bin_c == ZERO_VAL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q      <= RST_BIN;
         gray_q     <= RST_GRAY;
         wrap_q     <= 1'b0;
         at_limit_q <= 1'b0;
      end else begin
         bin_q      <= next_bin_c;
         gray_q     <= next_gray_c;
         wrap_q     <= next_wrap_c;
         at_limit_q <= next_at_limit_c;
      end
   end

   assign bus.bin_out  = bin_q;
   assign bus.gray_out = gray_q;
   assign bus.wrap     = wrap_q;
   assign bus.at_limit = at_limit_q;

endmodule
